// File: rtl/division_if.sv
// division_if -- request/result bundle for the iterative divider.
//   i_a, i_b     : dividend / divisor (BF16, or INT8 in [7:0])
//   i_vld        : request strobe, honoured only while o_busy is low
//   int8_ip      : operand format at acceptance (1 = INT8, 0 = BF16)
//   o_busy       : divider occupied, from acceptance through the result cycle
//   o_res        : result, held until the next result
//   o_res_vld    : one-cycle pulse with each new o_res
//   exception / overflow / underflow / div_by_zero : status flags, held with o_res
// The issuing side uses the master modport, the divider uses the slave modport.
interface division_if;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        i_vld;
  logic        int8_ip;
  logic        o_busy;
  logic [15:0] o_res;
  logic        o_res_vld;
  logic        exception;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  modport master (
    output i_a, i_b, i_vld, int8_ip,
    input  o_busy, o_res, o_res_vld, exception, overflow, underflow, div_by_zero
  );

  modport slave (
    input  i_a, i_b, i_vld, int8_ip,
    output o_busy, o_res, o_res_vld, exception, overflow, underflow, div_by_zero
  );
endinterface

// File: rtl/division.sv
// division -- radix-2 restoring divider for BF16 and INT8 operands.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset; discards any in-flight operation
//   bus : division_if.slave (operands, request, result, flags, busy)
// One operand pair is taken when idle, 17 quotient bits are produced one per
// cycle, and a final cycle rounds/classifies and registers the result. The
// result and flags appear 18 cycles after the accepting edge, for every input.
module division (
  input  logic      clk,
  input  logic      rst,
  division_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        int8_q, int8_d;
  logic [16:0] dvd_q, dvd_d;     // dividend, shifted out MSB first
  logic [7:0]  dvs_q, dvs_d;     // divisor magnitude / mantissa
  logic [4:0]  cnt_q, cnt_d;
  logic [9:0]  quo_q, quo_d;     // only the low 10 quotient bits are ever non-zero
  logic [7:0]  rem_q, rem_d;
  logic [15:0] res_q, res_d;
  logic        res_vld_q, res_vld_d;
  logic        exc_q, exc_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        dbz_q, dbz_d;

  // Operand conditioning at acceptance
  logic [7:0] abs_a, abs_b;
  assign abs_a = bus.i_a[7] ? (~bus.i_a[7:0] + 8'd1) : bus.i_a[7:0];
  assign abs_b = bus.i_b[7] ? (~bus.i_b[7:0] + 8'd1) : bus.i_b[7:0];

  // One restoring step: bring down the next dividend bit and try to subtract.
  // When the subtraction is taken the true difference is below the divisor,
  // so its low 8 bits are exact.
  logic [8:0] trial;
  logic       take;
  assign trial = {rem_q, dvd_q[16]};
  assign take  = (trial >= {1'b0, dvs_q});

  // Result formation (used in NORM)
  logic        sign;
  logic [7:0]  ea, eb;
  logic [6:0]  mant_raw;
  logic        guard, sticky, round_up;
  logic [7:0]  mant_sum;
  logic [6:0]  mant;
  logic [9:0]  e_pre, e_fin;
  logic [7:0]  q_int, r_int;
  logic [15:0] norm_res;
  logic        norm_exc, norm_ovf, norm_unf, norm_dbz;

  always_comb begin
    sign     = a_q[15] ^ b_q[15];
    ea       = a_q[14:7];
    eb       = b_q[14:7];
    mant_raw = 7'd0;
    guard    = 1'b0;
    sticky   = 1'b0;
    e_pre    = 10'd0;
    norm_res = 16'd0;
    norm_exc = 1'b0;
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    norm_dbz = 1'b0;

    // Quotient lies in [256,1023]; bit 9 tells whether ma >= mb.
    if (quo_q[9]) begin
      mant_raw = quo_q[8:2];
      guard    = quo_q[1];
      sticky   = quo_q[0] | (rem_q != 8'd0);
      e_pre    = {2'b00, ea} - {2'b00, eb} + 10'd127;
    end else begin
      mant_raw = quo_q[7:1];
      guard    = quo_q[0];
      sticky   = (rem_q != 8'd0);
      e_pre    = {2'b00, ea} - {2'b00, eb} + 10'd126;
    end
    round_up = guard & (sticky | mant_raw[0]);
    mant_sum = {1'b0, mant_raw} + {7'd0, round_up};
    // Carry out of the 7-bit fraction: 1.1111111 rounds to 10.0000000
    if (mant_sum[7]) begin
      mant  = 7'd0;
      e_fin = e_pre + 10'd1;
    end else begin
      mant  = mant_sum[6:0];
      e_fin = e_pre;
    end

    // INT8: magnitudes were divided; restore signs
    q_int = (a_q[7] ^ b_q[7]) ? (~quo_q[7:0] + 8'd1) : quo_q[7:0];
    r_int = a_q[7] ? (~rem_q + 8'd1) : rem_q;

    if (int8_q) begin
      if (b_q[7:0] == 8'd0) begin
        norm_dbz = 1'b1;
        norm_res = {a_q[7:0], (a_q[7] ? 8'h80 : 8'h7F)};
      end else if (a_q[7:0] == 8'h80 && b_q[7:0] == 8'hFF) begin
        norm_ovf = 1'b1;
        norm_res = 16'h007F;
      end else begin
        norm_res = {r_int, q_int};
      end
    end else begin
      if (ea == 8'hFF || eb == 8'hFF) begin
        norm_exc = 1'b1;
        norm_res = 16'd0;
      end else if (eb == 8'd0) begin
        norm_dbz = 1'b1;
        norm_res = {sign, 8'hFF, 7'd0};
      end else if (ea == 8'd0) begin
        norm_res = {sign, 15'd0};
      end else if ($signed(e_fin) >= 10'sd255) begin
        norm_ovf = 1'b1;
        norm_res = {sign, 8'hFF, 7'd0};
      end else if ($signed(e_fin) <= 10'sd0) begin
        norm_unf = 1'b1;
        norm_res = {sign, 15'd0};
      end else begin
        norm_res = {sign, e_fin[7:0], mant};
      end
    end
  end

  // Control FSM and datapath next-state
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    int8_d    = int8_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    exc_d     = exc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_vld) begin
          a_d    = bus.i_a;
          b_d    = bus.i_b;
          int8_d = bus.int8_ip;
          if (bus.int8_ip) begin
            dvd_d = {9'd0, abs_a};
            dvs_d = abs_b;
          end else begin
            dvd_d = {1'b1, bus.i_a[6:0], 9'd0};
            dvs_d = {1'b1, bus.i_b[6:0]};
          end
          cnt_d   = 5'd16;
          quo_d   = 10'd0;
          rem_d   = 8'd0;
          state_d = DIV;
        end
      end
      DIV: begin
        dvd_d = {dvd_q[15:0], 1'b0};
        rem_d = take ? (trial[7:0] - dvs_q) : trial[7:0];
        quo_d = {quo_q[8:0], take};
        if (cnt_q == 5'd0) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      NORM: begin
        res_d     = norm_res;
        exc_d     = norm_exc;
        ovf_d     = norm_ovf;
        unf_d     = norm_unf;
        dbz_d     = norm_dbz;
        res_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= 16'd0;
      b_q       <= 16'd0;
      int8_q    <= 1'b0;
      dvd_q     <= 17'd0;
      dvs_q     <= 8'd0;
      cnt_q     <= 5'd0;
      quo_q     <= 10'd0;
      rem_q     <= 8'd0;
      res_q     <= 16'd0;
      res_vld_q <= 1'b0;
      exc_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      int8_q    <= int8_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      exc_q     <= exc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_res       = res_q;
  assign bus.o_res_vld   = res_vld_q;
  assign bus.exception   = exc_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_division.sv
// tb_division -- scoreboard bench for the divider. Expected results come from
// an independent arithmetic model (exact remainder-based rounding for BF16,
// native signed division for INT8), are queued at drive time and popped when
// o_res_vld is seen.
module tb_division;

  logic clk;
  logic rst;
  division_if bus ();

  division u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int op_cnt  = 0;
  logic [19:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, underflow, overflow, exception, o_res}
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic m);
    int ea, eb, ma, mb, e, num, t, r, sa, sb, q, rr;
    logic s;
    logic [31:0] tv, ev, qv, rv;
    if (m) begin
      sa = int'($signed(a[7:0]));
      sb = int'($signed(b[7:0]));
      if (sb == 0) return {4'b1000, a[7:0], (a[7] ? 8'h80 : 8'h7F)};
      if (sa == -128 && sb == -1) return {4'b0010, 16'h007F};
      q  = sa / sb;
      rr = sa % sb;
      qv = q;
      rv = rr;
      return {4'b0000, rv[7:0], qv[7:0]};
    end
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    ma = 128 + int'(a[6:0]);
    mb = 128 + int'(b[6:0]);
    if (ea == 255 || eb == 255) return {4'b0001, 16'h0000};
    if (eb == 0) return {4'b1000, s, 8'hFF, 7'h00};
    if (ea == 0) return {4'b0000, s, 15'h0000};
    // scale ma/mb into [128,256) and round to nearest even on the exact remainder
    if (ma >= mb) begin
      num = ma << 7;
      e   = ea - eb + 127;
    end else begin
      num = ma << 8;
      e   = ea - eb + 126;
    end
    t = num / mb;
    r = num % mb;
    if (2 * r > mb || (2 * r == mb && (t % 2) == 1)) t++;
    if (t == 256) begin
      t = 128;
      e++;
    end
    if (e >= 255) return {4'b0010, s, 8'hFF, 7'h00};
    if (e <= 0) return {4'b0100, s, 15'h0000};
    tv = t;
    ev = e;
    return {4'b0000, s, ev[7:0], tv[6:0]};
  endfunction

  function automatic logic [19:0] observed();
    return {bus.div_by_zero, bus.underflow, bus.overflow, bus.exception, bus.o_res};
  endfunction

  // Called at a falling edge; returns at a falling edge with o_busy low.
  task automatic wait_idle();
    int n = 0;
    while (bus.o_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one request and score its result. With inject set, new operands are
  // pulsed on i_vld 5 and 10 cycles after acceptance and must be ignored.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic m, input bit inject);
    int lat;
    bit got;
    logic [19:0] exp_v;
    wait_idle();
    bus.i_a     = a;
    bus.i_b     = b;
    bus.int8_ip = m;
    bus.i_vld   = 1'b1;
    sb_q.push_back(model(a, b, m));
    @(posedge clk);
    #1;
    bus.i_vld   = 1'b0;
    bus.i_a     = 16'($urandom);
    bus.i_b     = 16'($urandom);
    bus.int8_ip = 1'($urandom);
    lat = 0;
    got = 0;
    while (lat < 40 && !got) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) check("busy_after_accept", {31'd0, bus.o_busy}, 32'd1);
      if (inject && (lat == 5 || lat == 10)) begin
        bus.i_a     = 16'($urandom);
        bus.i_b     = 16'($urandom);
        bus.int8_ip = ~m;
        bus.i_vld   = 1'b1;
      end else begin
        bus.i_vld = 1'b0;
      end
      if (bus.o_res_vld) got = 1;
    end
    bus.i_vld = 1'b0;
    exp_v = sb_q.pop_front();
    check("latency", lat, 32'd18);
    check("result", {12'd0, observed()}, {12'd0, exp_v});
    check("busy_at_result", {31'd0, bus.o_busy}, 32'd0);
    op_cnt++;
    $display("op %0d: a=%h b=%h int8=%0d -> res=%h flags(dbz,unf,ovf,exc)=%b exp=%h lat=%0d",
             op_cnt, a, b, m, bus.o_res, observed() >> 16, exp_v, lat);
    @(negedge clk);
    check("vld_single_pulse", {31'd0, bus.o_res_vld}, 32'd0);
    check("result_held", {12'd0, observed()}, {12'd0, exp_v});
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rm;
    bit          seen;

    rst         = 1'b1;
    bus.i_a     = 16'd0;
    bus.i_b     = 16'd0;
    bus.i_vld   = 1'b0;
    bus.int8_ip = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_res", {16'd0, bus.o_res}, 32'd0);
    check("reset_vld", {31'd0, bus.o_res_vld}, 32'd0);
    check("reset_busy", {31'd0, bus.o_busy}, 32'd0);
    check("reset_flags", {28'd0, observed() >> 16}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(16'h40C0, 16'h4000, 1'b0, 0);   // 6/2 = 3
    run_op(16'h3F80, 16'h4040, 1'b0, 0);   // 1/3 rounds up
    run_op(16'h7F00, 16'h0080, 1'b0, 0);   // overflow
    run_op(16'h3F80, 16'h8000, 1'b0, 0);   // divide by -0
    run_op(16'h7F80, 16'h4000, 1'b0, 0);   // Inf dividend
    run_op(16'h3F80, 16'hFFC0, 1'b0, 0);   // NaN divisor
    run_op(16'h0080, 16'h7F00, 1'b0, 0);   // underflow
    run_op(16'h8000, 16'h4000, 1'b0, 0);   // zero dividend
    run_op(16'h00F9, 16'h0002, 1'b1, 0);   // -7/2
    run_op(16'h0080, 16'h00FF, 1'b1, 0);   // -128/-1
    run_op(16'h00F0, 16'h0000, 1'b1, 0);   // divide by zero, negative dividend
    run_op(16'h0035, 16'h0000, 1'b1, 0);   // divide by zero, positive dividend
    run_op(16'h0080, 16'h0001, 1'b1, 0);   // -128/1
    run_op(16'h0064, 16'h00F9, 1'b1, 0);   // 100/-7

    // Requests while busy must be ignored
    run_op(16'h4120, 16'h3FC0, 1'b0, 1);
    run_op(16'h007F, 16'h00FD, 1'b1, 1);

    // Reset in the middle of an operation
    wait_idle();
    bus.i_a     = 16'h40C0;
    bus.i_b     = 16'h4000;
    bus.int8_ip = 1'b0;
    bus.i_vld   = 1'b1;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_res", {16'd0, bus.o_res}, 32'd0);
    check("rst_vld", {31'd0, bus.o_res_vld}, 32'd0);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.o_res_vld) seen = 1;
    end
    check("no_vld_after_rst", {31'd0, seen}, 32'd0);
    op_cnt++;
    $display("op %0d: reset mid-operation, o_res_vld seen afterwards=%0d", op_cnt, seen);
    run_op(16'h40C0, 16'h4000, 1'b0, 0);

    // Random mix
    for (int i = 0; i < 30; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rm) begin
        if (i % 7 == 0) rb[7:0] = 8'd0;
      end else if (i % 4 != 0) begin
        ra[14:7] = 8'($urandom_range(100, 150));
        rb[14:7] = 8'($urandom_range(100, 150));
      end
      run_op(ra, rb, rm, 0);
    end

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/division.md
# division

Iterative divider for the BF16/INT8 arithmetic unit: the inverse operation to the team's multiplier, sharing its operand formats, mode input and flag outputs. It accepts one operand pair per request and runs a radix-2 restoring divide, one quotient bit per cycle. It returns a registered result with a one-cycle valid pulse after a fixed latency. A busy output lets the issuing logic throttle requests.

## Interface
- Parameters: none (formats fixed: BF16 = 1/8/7, INT8 two's complement in bits [7:0])
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_a  in  16  dividend (BF16, or INT8 in [7:0] when int8_ip=1)
- i_b  in  16  divisor (same format)
- i_vld  in  1  request; accepted only when o_busy=0
- int8_ip  in  1  mode at acceptance: 1 = INT8, 0 = BF16
- o_busy  out  1  high from acceptance through result cycle
- o_res  out  16  result, held until next result
- o_res_vld  out  1  one-cycle pulse with each new o_res
- exception  out  1  BF16 operand exponent all-ones (Inf/NaN)
- overflow  out  1  result saturated high
- underflow  out  1  BF16 result flushed to zero
- div_by_zero  out  1  divisor zero

## Operation
- States: IDLE, DIV (17 iterations), NORM (1 cycle).
- IDLE: when i_vld=1, latch i_a, i_b and int8_ip, then go to DIV. When i_vld=0, stay in IDLE.
- DIV: divisor is 8-bit, dividend is 17-bit; the counter runs from 16 down to 0. After the count-0 cycle, go to NORM.
- NORM: compute the result, register o_res and all flags, pulse o_res_vld, go to IDLE.
- Latency is fixed for all inputs, including special cases. Specials are decided in NORM.
- BF16 datapath:
  - sign = a[15]^b[15].
  - Exponent 0 (zero or denormal) is treated as zero.
  - Mantissas are {1,m[6:0]}.
  - Dividend = {ma,9'b0}, so the quotient q[9:0] is in [256,1023]. rem = remainder.
  - If q[9]=1: mant=q[8:2], guard=q[1], sticky=q[0]|(rem!=0), E = ea - eb + 127.
  - Else: mant=q[7:1], guard=q[0], sticky=(rem!=0), E = ea - eb + 126.
  - Round to nearest even: increment mant when guard & (sticky|mant[0]). A mant carry-out sets mant=0 and increments E.
  - E is computed as signed 10-bit.
- BF16 result priority:
  1. exception (either exponent 8'hFF): o_res=0.
  2. div_by_zero (eb=0): o_res={sign,8'hFF,7'b0}.
  3. zero dividend (ea=0): o_res={sign,15'b0}, no flags.
  4. E≥255: overflow, o_res={sign,8'hFF,7'b0}.
  5. E≤0: underflow, o_res={sign,15'b0}.
  6. Otherwise: o_res={sign,E[7:0],mant}.
- INT8 datapath:
  - Divide |a[7:0]| by |b[7:0]|; the quotient truncates toward zero.
  - The quotient is negated if a[7]^b[7]. The remainder takes the sign of the dividend.
  - o_res = {remainder[7:0], quotient[7:0]}.
  - -128 / -1: overflow=1, o_res=16'h007F.
  - b=0: div_by_zero=1, quotient = a≥0 ? 8'h7F : 8'h80, remainder = a[7:0].
  - exception and underflow are always 0 in INT8 mode.
- Flags are registered with o_res and hold until the next o_res_vld.

## Timing
- Reset: state IDLE; o_res=0, o_res_vld=0, o_busy=0, all flags 0. Any in-flight operation is discarded with no o_res_vld.
- rst has priority over i_vld on the same edge.
- Request accepted at edge N: o_busy=1 from after edge N. o_res, flags and o_res_vld=1 are visible after edge N+18; o_busy=0 at that time.
- Next acceptance is possible at edge N+19; throughput is one result per 19 cycles.
- i_vld while o_busy=1 is ignored; it is neither queued nor allowed to corrupt the latched operands.
- Input changes after acceptance do not affect the in-flight result.
- o_res_vld is high for exactly one cycle per accepted request.

## Test plan
- BF16 a=16'h40C0 (6.0), b=16'h4000 (2.0) -> o_res=16'h4040, all flags 0, o_res_vld exactly 18 cycles after acceptance edge.
- BF16 a=16'h3F80 (1.0), b=16'h4040 (3.0) -> o_res=16'h3EAB (rounding up). Also a=16'h7F00, b=16'h0080 -> overflow=1, o_res=16'h7F80.
- BF16 a=16'h3F80, b=16'h8000 -> div_by_zero=1, o_res=16'hFF80. Also a=16'h7F80 (Inf), any b -> exception=1, o_res=0.
- INT8 a=16'h00F9 (-7), b=16'h0002 -> o_res=16'hFFFD (rem -1, quot -3). Also a=16'h0080, b=16'h00FF -> overflow=1, o_res=16'h007F.
- INT8 b=0, a=16'h00F0 -> div_by_zero=1, o_res=16'hF080.
- Pulse i_vld with new operands at cycles 5 and 10 after acceptance: ignored, result matches the first request. Assert rst at cycle 9: next cycle o_busy=0, o_res=0, no o_res_vld; a fresh request then completes normally.
